// File: rtl/vga_pkg.sv
// Shared definitions for the VGA console port: bus address map, STATUS
// register layout, output FSM state type and the STATUS packing helper.
package vga_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  // Bit in a STATUS write that clears the sticky overflow flag
  localparam int unsigned CLR_OVF_BIT = 1;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_COUNT_LSB = 3;
  localparam int unsigned STAT_COUNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [31:0] pack_status(
    input logic [STAT_COUNT_W-1:0] count,
    input logic                    overflow,
    input logic                    full,
    input logic                    empty
  );
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    s[STAT_OVF]                       = overflow;
    s[STAT_FULL]                      = full;
    s[STAT_EMPTY]                     = empty;
    return s;
  endfunction

endpackage

// File: rtl/vga_console_port_if.sv
// MMIO bus bundle between the SoC interconnect and the console port.
interface vga_console_port_if;

  logic        bus_sel;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/vga_console_port_sync_fifo.sv
// Single-clock circular FIFO. Head word is presented combinationally on
// rdata; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Qualify requests with the current occupancy
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_console_port.sv
// CPU-side console port: buffers character words written over MMIO and
// replays them as paced dataWrite/dataReady strobes for the typewriter.
module vga_console_port #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned DATA_WIDTH  = vga_pkg::DATA_WIDTH
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  vga_console_port_if.slave     bus,
  output logic [DATA_WIDTH-1:0] dataWrite,
  output logic                  dataReady
);

  import vga_pkg::*;

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  logic                  data_wr;
  logic                  status_wr;
  logic                  status_rd;
  logic                  push;
  logic                  pop;
  logic                  overflow;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  state_t                state;
  state_t                state_n;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_n;

  // Bus access decode
  always_comb begin
    data_wr   = bus.bus_sel && bus.bus_we  && (bus.bus_addr == ADDR_DATA);
    status_wr = bus.bus_sel && bus.bus_we  && (bus.bus_addr == ADDR_STATUS);
    status_rd = bus.bus_sel && !bus.bus_we && (bus.bus_addr == ADDR_STATUS);
    push      = data_wr;
  end

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk_50m),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.bus_wdata[DATA_WIDTH-1:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: set by a DATA write that finds the FIFO full (occupancy
  // before any same-cycle pop), cleared by software via STATUS
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (status_wr && bus.bus_wdata[CLR_OVF_BIT]) begin
      overflow <= 1'b0;
    end else if (data_wr && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Registered ack and read data; every access completes one cycle later
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      bus.bus_ready <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      bus.bus_ready <= bus.bus_sel;
      if (status_rd) begin
        bus.bus_rdata <= pack_status(STAT_COUNT_W'(fifo_count), overflow,
                                     fifo_full, fifo_empty);
      end else begin
        bus.bus_rdata <= '0;
      end
    end
  end

  // Output pacing FSM: next state, counter and pop request
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_n   = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // FSM registers; strobe is registered from the next state so it is
  // glitch-free and rises the cycle after the pop
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dataWrite <= '0;
      dataReady <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dataReady <= (state_n == HOLD);
      if (pop) begin
        dataWrite <= fifo_head;
      end
    end
  end

endmodule
